// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: memory word, RAM handshake state and arbiter FSM state.
// Imported by the memory arbiter and any block that talks to the RAM model.
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DSERVE = 2'd1,
      ISERVE = 2'd2,
      RETRY  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache: data side has priority,
// a saturating starvation counter forces an instruction grant, RAM errors are retried.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int ADDR_W     = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [ADDR_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [ADDR_W-1:0] dstore,
   output logic              dwait,
   output logic [ADDR_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [ADDR_W-1:0] ramstore,
   input  logic [ADDR_W-1:0] ramload,
   input  ramstate_t         ramstate
);

   localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

   arb_state_t        r_state;
   logic              r_ret_i;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_store;
   logic [3:0]        r_starve;

   logic w_dreq;
   logic w_force_i;
   logic w_dcomp;
   logic w_icomp;

   assign w_dreq    = dREN | dWEN;
   assign w_force_i = iREN & (r_starve >= LP_STARVE_MAX);

   // A completion needs the granted requester still present; a dropped request never sees wait low.
   assign w_dcomp = (r_state == DSERVE) & w_dreq & (ramstate == ACCESS);
   assign w_icomp = (r_state == ISERVE) & iREN   & (ramstate == ACCESS);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= IDLE;
         r_ret_i  <= 1'b0;
         r_wr     <= 1'b0;
         r_addr   <= '0;
         r_store  <= '0;
         r_starve <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!iREN) r_starve <= '0;
               if (w_dreq && !w_force_i) begin
                  r_addr  <= daddr;
                  r_store <= dstore;
                  r_wr    <= dWEN;
                  r_state <= DSERVE;
               end else if (iREN) begin
                  r_addr  <= iaddr;
                  r_store <= '0;
                  r_wr    <= 1'b0;
                  r_state <= ISERVE;
               end
            end
            DSERVE: begin
               if (!w_dreq) begin
                  r_state <= IDLE;
               end else if (ramstate == ACCESS) begin
                  r_state <= IDLE;
                  if (iREN && (r_starve < LP_STARVE_MAX)) r_starve <= r_starve + 4'd1;
               end else if (ramstate == ERROR) begin
                  r_ret_i <= 1'b0;
                  r_state <= RETRY;
               end
            end
            ISERVE: begin
               if (!iREN) begin
                  r_state <= IDLE;
               end else if (ramstate == ACCESS) begin
                  r_state  <= IDLE;
                  r_starve <= '0;
               end else if (ramstate == ERROR) begin
                  r_ret_i <= 1'b1;
                  r_state <= RETRY;
               end
            end
            RETRY: begin
               // Reissue the same latched grant unless its requester went away meanwhile.
               if (r_ret_i) r_state <= iREN   ? ISERVE : IDLE;
               else         r_state <= w_dreq ? DSERVE : IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ramREN   = (r_state == ISERVE) | ((r_state == DSERVE) & ~r_wr);
   assign ramWEN   = (r_state == DSERVE) & r_wr;
   assign ramaddr  = r_addr;
   assign ramstore = r_store;

   assign iwait = ~w_icomp;
   assign dwait = ~w_dcomp;
   assign iload = w_icomp ? ramload : '0;
   assign dload = (w_dcomp && !r_wr) ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// sequences for starvation and mid-transaction reset.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   ramstate_t   ramstate;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(.STARVE_MAX(4), .ADDR_W(32)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   typedef struct {
      logic        iren;
      logic [31:0] iaddr;
      logic        dren;
      logic        dwen;
      logic [31:0] daddr;
      logic [31:0] dstore;
      ramstate_t   rs;
      logic [31:0] rload;
      logic [131:0] exp;
   } vec_t;

   vec_t tbl [19];
   byte  ev [$];

   function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dw, input logic [31:0] da, input logic [31:0] ds,
                               input ramstate_t rs, input logic [31:0] rl,
                               input logic ren, input logic wen, input logic [31:0] ra,
                               input logic [31:0] rst_, input logic iw, input logic [31:0] il,
                               input logic dwt, input logic [31:0] dl);
      vec_t v;
      v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw;
      v.daddr = da; v.dstore = ds; v.rs = rs; v.rload = rl;
      v.exp = {ren, wen, ra, rst_, iw, il, dwt, dl};
      return v;
   endfunction

   function automatic logic [131:0] outs();
      return {ramREN, ramWEN, ramaddr, ramstore, iwait, iload, dwait, dload};
   endfunction

   task automatic check_outs(input string name, input logic [131:0] exp);
      checks++;
      if (outs() !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, outs(), exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] ds, input ramstate_t rs,
                        input logic [31:0] rl);
      iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
      daddr = da; dstore = ds; ramstate = rs; ramload = rl;
   endtask

   // Records which side completes on each cycle; flags any cycle where both waits are low.
   task automatic collect(input int ncyc);
      logic both;
      both = 1'b0;
      ev.delete();
      for (int c = 0; c < ncyc; c++) begin
         #1;
         if (!iwait && !dwait) both = 1'b1;
         if (!dwait) ev.push_back("D");
         if (!iwait) ev.push_back("I");
         @(negedge CLK);
      end
      checks++;
      if (both) begin
         errors++;
         $display("FAIL both_wait_low: got 1 expected 0");
      end
   endtask

   task automatic check_seq(input string name, input string exp);
      byte got;
      for (int i = 0; i < exp.len(); i++) begin
         got = (i < ev.size()) ? ev[i] : "-";
         checks++;
         if (got != exp[i]) begin
            errors++;
            $display("FAIL %s[%0d]: got %c expected %c", name, i, got, exp[i]);
         end
      end
   endtask

   initial begin
      tbl[0]  = mk(1, 32'h40, 0, 0, 0, 0, BUSY, 0,            0, 0, 32'h0,   0, 1, 0, 1, 0);
      tbl[1]  = mk(1, 32'h40, 0, 0, 0, 0, BUSY, 0,            1, 0, 32'h40,  0, 1, 0, 1, 0);
      tbl[2]  = mk(1, 32'h40, 0, 0, 0, 0, BUSY, 0,            1, 0, 32'h40,  0, 1, 0, 1, 0);
      tbl[3]  = mk(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h8C010004,
                   1, 0, 32'h40, 0, 0, 32'h8C010004, 1, 0);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0, FREE, 0,                 0, 0, 32'h40,  0, 1, 0, 1, 0);
      tbl[5]  = mk(1, 32'h10, 0, 1, 32'h200, 32'hDEADBEEF, ACCESS, 0,
                   0, 0, 32'h40, 0, 1, 0, 1, 0);
      tbl[6]  = mk(1, 32'h10, 0, 1, 32'h200, 32'hDEADBEEF, ACCESS, 0,
                   0, 1, 32'h200, 32'hDEADBEEF, 1, 0, 0, 0);
      tbl[7]  = mk(1, 32'h10, 0, 0, 0, 0, ACCESS, 0,
                   0, 0, 32'h200, 32'hDEADBEEF, 1, 0, 1, 0);
      tbl[8]  = mk(1, 32'h10, 0, 0, 0, 0, ACCESS, 32'h11111111,
                   1, 0, 32'h10, 0, 0, 32'h11111111, 1, 0);
      tbl[9]  = mk(0, 0, 1, 0, 32'h300, 0, FREE, 0,           0, 0, 32'h10,  0, 1, 0, 1, 0);
      tbl[10] = mk(0, 0, 1, 0, 32'h300, 0, ERROR, 0,          1, 0, 32'h300, 0, 1, 0, 1, 0);
      tbl[11] = mk(0, 0, 1, 0, 32'h300, 0, FREE, 0,           0, 0, 32'h300, 0, 1, 0, 1, 0);
      tbl[12] = mk(0, 0, 1, 0, 32'h300, 0, ACCESS, 32'h1234,  1, 0, 32'h300, 0, 1, 0, 0, 32'h1234);
      tbl[13] = mk(1, 32'h80, 1, 0, 32'h500, 0, FREE, 0,      0, 0, 32'h300, 0, 1, 0, 1, 0);
      tbl[14] = mk(1, 32'h80, 1, 0, 32'h500, 0, BUSY, 0,      1, 0, 32'h500, 0, 1, 0, 1, 0);
      tbl[15] = mk(1, 32'h80, 0, 0, 32'h500, 0, BUSY, 0,      1, 0, 32'h500, 0, 1, 0, 1, 0);
      tbl[16] = mk(1, 32'h80, 0, 0, 0, 0, ACCESS, 32'h5555,   0, 0, 32'h500, 0, 1, 0, 1, 0);
      tbl[17] = mk(1, 32'h80, 0, 0, 0, 0, ACCESS, 32'h5555,   1, 0, 32'h80,  0, 0, 32'h5555, 1, 0);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, FREE, 0,                 0, 0, 32'h80,  0, 1, 0, 1, 0);

      RST = 1'b1;
      drive(0, 0, 0, 0, 0, 0, FREE, 0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check_outs("reset", {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0});

      // Read-only, simultaneous, error retry and request drop, one row per cycle.
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].iren, tbl[i].iaddr, tbl[i].dren, tbl[i].dwen,
               tbl[i].daddr, tbl[i].dstore, tbl[i].rs, tbl[i].rload);
         #1;
         check_outs($sformatf("row%0d", i), tbl[i].exp);
         @(negedge CLK);
      end

      // Starvation: both sides request continuously, RAM always ready.
      drive(1, 32'h900, 1, 0, 32'h700, 0, ACCESS, 32'hABCD);
      collect(20);
      check_seq("starve", "DDDDIDDDDI");

      // Build up the starve count, then reset in the middle of a data grant.
      collect(6);
      check_seq("prefill", "DDD");
      ramstate = BUSY;
      @(negedge CLK);
      #1;
      checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h700) begin
         errors++;
         $display("FAIL dserve_before_reset: got ren=%b addr=%h expected ren=1 addr=00000700",
                  ramREN, ramaddr);
      end
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check_outs("mid_reset", {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0});
      ramstate = ACCESS;
      collect(12);
      check_seq("after_reset", "DDDDID");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-core memory controller directly downstream of the I/D cache block.
- Takes the icache request (iREN/iaddr) and the dcache request (dREN/dWEN/daddr/dstore), grants one at a time to the single-port RAM, and returns iwait/iload and dwait/dload.
- Data side has priority. A starvation counter guarantees instruction fetch progress.
- Handles RAM ERROR by deasserting strobes for one cycle and reissuing.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while iREN is pending before one instruction grant is forced (range 1..15).
- ADDR_W, 32: address/data width (word_t).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous active-high reset
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache word address
- iwait  out  1  low for exactly the completion cycle of an instruction grant
- iload  out  ADDR_W  instruction word; valid only when iwait=0
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache address
- dstore  in  ADDR_W  dcache write data
- dwait  out  1  low for exactly the completion cycle of a data grant
- dload  out  ADDR_W  read data; valid only when dwait=0
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  ADDR_W  RAM write data
- ramload  in  ADDR_W  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- States are IDLE, DSERVE, ISERVE, RETRY.
- Reset (any state, mid-transaction included): state=IDLE, starve counter=0, grant registers=0.
  - Outputs after reset: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
- Outputs outside a completion cycle: iwait=dwait=1 and iload=dload=0.
- IDLE:
  - No strobes driven.
  - Data request pending (dREN|dWEN) and not (iREN and starve>=STARVE_MAX): latch daddr, dstore, op (write if dWEN, dWEN wins if both asserted) -> DSERVE.
  - Else iREN: latch iaddr -> ISERVE.
  - Else stay.
- DSERVE/ISERVE:
  - Drive ramaddr/ramstore/strobe from the latched grant only, never from live inputs.
  - ramREN for reads and ISERVE, ramWEN for writes.
  - ramstate==ACCESS: the granted side's wait=0 this cycle; load=ramload combinationally (reads); store accepted (writes). Next state IDLE.
  - ramstate==ERROR: strobes stay asserted this cycle -> RETRY.
  - FREE/BUSY: hold.
- RETRY: strobes=0 for one cycle, then back to the previous serve state with the same latched grant.
- Requester drop: if the granted request is deasserted before ACCESS, strobes drop the next cycle and state returns to IDLE. No wait pulse is issued.
- Starve counter (4-bit, saturating at STARVE_MAX):
  - On a DSERVE completion with iREN high: increment.
  - On an ISERVE completion, or whenever iREN is low in IDLE: clear.
- Latency: request visible in IDLE at cycle N; strobes at N+1; earliest wait-low at N+1 (RAM returns ACCESS immediately).
- Back-to-back: after a completion, at least one IDLE cycle precedes the next grant.
- Only the granted side ever sees wait=0. Never both in one cycle.
- Only latched addresses reach ramaddr, so it is glitch-free across grants.

Decomposition:
- Shared package cpu_types_pkg holds:
  - word_t, ramstate_t (FREE/BUSY/ACCESS/ERROR)
  - a new arb_state_t enum (IDLE/DSERVE/ISERVE/RETRY)
- No sub-module required.
- The starvation counter may be a local always_ff. A separate arb_starve_ctr is optional but not needed.

Test Plan:
- Read only: reset, iREN=1, iaddr=0x40, ramstate BUSY x2 then ACCESS with ramload=0x8C010004 -> ramREN=1, ramaddr=0x40 from cycle 1; iwait=0 and iload=0x8C010004 on cycle 3 only; dwait stays 1.
- Simultaneous: iREN=1 at 0x10 and dWEN=1 at 0x200 with dstore=0xDEADBEEF, RAM ACCESS immediately -> data granted first: ramWEN=1, ramaddr=0x200, ramstore=0xDEADBEEF. Next grant is instruction, ramaddr=0x10.
- Starvation (STARVE_MAX=4): dREN held high continuously, iREN high -> exactly 4 data completions, then one instruction completion, then data resumes.
- Error retry: dREN at 0x300, ramstate ERROR once, then ACCESS with ramload=0x1234 -> one cycle with ramREN=0 (RETRY), reissue at 0x300, dwait=0 and dload=0x1234.
- Mid-transaction reset: RST=1 during DSERVE while ramstate=BUSY -> next cycle strobes=0, iwait=dwait=1, state IDLE, starve=0.
- Request drop: dREN deasserted while BUSY -> strobes drop next cycle, no dwait pulse, pending iREN granted afterwards.
